// File: rtl/rv64_multicycle_ctrl.sv
// Multi-cycle control FSM for the RV64 single-issue datapath: sequences fetch,
// decode, execute, memory and write-back, with illegal-opcode and timeout detection.
module rv64_multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      inst,
    output logic             ir_load,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    input  logic             alu_zero,
    output logic             alu_src_imm,
    output logic             rf_wen,
    output logic             wb_sel,
    output logic             pc_write,
    output logic             pc_sel,
    output logic             illegal,
    output logic             timeout,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retire_count
);

    localparam int unsigned WAIT_W = 8;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERROR  = 3'd7
    } state_t;

    state_t              state_q, state_d;
    logic [6:0]          opcode_q;
    logic [4:0]          rd_q;
    logic [WAIT_W-1:0]   wait_q;
    logic                illegal_q, timeout_q;
    logic [CNT_W-1:0]    count_q;
    logic                set_illegal, set_timeout;
    logic                wait_tick, timeout_hit;
    logic                is_r, is_i, is_load, is_store, is_branch, is_legal;
    logic                unused_inst_bits;

    assign unused_inst_bits = ^inst[31:12];

    assign is_r      = (opcode_q == OP_R);
    assign is_i      = (opcode_q == OP_I);
    assign is_load   = (opcode_q == OP_LOAD);
    assign is_store  = (opcode_q == OP_STORE);
    assign is_branch = (opcode_q == OP_BRANCH);
    assign is_legal  = is_r | is_i | is_load | is_store | is_branch;

    // A request cycle without its ack; the last permitted one trips the timeout.
    assign wait_tick   = ((state_q == S_FETCH) && !imem_ack) || ((state_q == S_MEM) && !dmem_ack);
    assign timeout_hit = wait_tick && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d     = S_ERROR;
                    set_timeout = 1'b1;
                end
            end
            S_DECODE: begin
                if (is_legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d     = S_ERROR;
                    set_illegal = 1'b1;
                end
            end
            S_EXEC: begin
                if (is_branch) begin
                    state_d = S_FETCH;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    state_d = is_load ? S_WB : S_FETCH;
                end else if (timeout_hit) begin
                    state_d     = S_ERROR;
                    set_timeout = 1'b1;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase
    end

    always_comb begin
        imem_req    = 1'b0;
        ir_load     = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        alu_src_imm = 1'b0;
        rf_wen      = 1'b0;
        wb_sel      = 1'b0;
        pc_write    = 1'b0;
        pc_sel      = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_load  = imem_ack;
                end
                S_EXEC: begin
                    alu_src_imm = is_i | is_load | is_store;
                    if (is_branch) begin
                        pc_write = 1'b1;
                        pc_sel   = alu_zero;
                    end
                end
                S_MEM: begin
                    dmem_req    = 1'b1;
                    dmem_we     = is_store;
                    alu_src_imm = 1'b1;
                    pc_write    = dmem_ack && is_store;
                end
                S_WB: begin
                    rf_wen   = (rd_q != 5'd0);
                    wb_sel   = is_load;
                    pc_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Instruction fields, wait counter, sticky flags and retire counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            opcode_q  <= 7'd0;
            rd_q      <= 5'd0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            count_q   <= '0;
        end else begin
            if ((state_q == S_FETCH) && imem_ack) begin
                opcode_q <= inst[6:0];
                rd_q     <= inst[11:7];
            end
            if (state_d != state_q) begin
                wait_q <= '0;
            end else if (wait_tick) begin
                wait_q <= wait_q + WAIT_W'(1);
            end
            if (set_illegal) illegal_q <= 1'b1;
            if (set_timeout) timeout_q <= 1'b1;
            if (pc_write)    count_q   <= count_q + CNT_W'(1);
        end
    end

    assign illegal      = illegal_q & ~reset;
    assign timeout      = timeout_q & ~reset;
    assign state        = reset ? 3'd0 : 3'(state_q);
    assign retire_count = reset ? '0 : count_q;

endmodule

// File: tb/tb_rv64_multicycle_ctrl.sv
// Randomized bench for rv64_multicycle_ctrl: per-instruction expected cycle traces
// built from instruction class and chosen memory latencies.
module tb_rv64_multicycle_ctrl;

    localparam int unsigned TO = 4;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          imem_ack = 1'b0, dmem_ack = 1'b0, alu_zero = 1'b0;
    logic [31:0]   inst = 32'd0;
    logic          imem_req, ir_load, dmem_req, dmem_we, alu_src_imm;
    logic          rf_wen, wb_sel, pc_write, pc_sel, illegal, timeout;
    logic [2:0]    state;
    logic [CW-1:0] retire_count;

    rv64_multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_ack(imem_ack), .inst(inst), .ir_load(ir_load),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .alu_zero(alu_zero), .alu_src_imm(alu_src_imm), .rf_wen(rf_wen),
        .wb_sel(wb_sel), .pc_write(pc_write), .pc_sel(pc_sel),
        .illegal(illegal), .timeout(timeout), .state(state),
        .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    typedef enum int {C_R, C_I, C_LD, C_ST, C_BR, C_ILL} cls_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_cnt  = 0;
    logic exp_ill  = 1'b0;
    logic exp_to   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic cls_t classify(input logic [6:0] op);
        case (op)
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b0000011: return C_LD;
            7'b0100011: return C_ST;
            7'b1100011: return C_BR;
            default:    return C_ILL;
        endcase
    endfunction

    function automatic logic [31:0] observed();
        return 32'({state, imem_req, ir_load, dmem_req, dmem_we, alu_src_imm,
                    rf_wen, wb_sel, pc_write, pc_sel, illegal, timeout, retire_count});
    endfunction

    // stb: {imem_req, ir_load, dmem_req, dmem_we, alu_src_imm, rf_wen, wb_sel, pc_write, pc_sel}
    task automatic cyc(input string tag, input logic ia, input logic da, input logic z,
                       input logic [31:0] iw, input logic [8:0] stb, input logic [2:0] st);
        @(negedge clk);
        reset = 1'b0; imem_ack = ia; dmem_ack = da; alu_zero = z; inst = iw;
        #1;
        check(tag, observed(), 32'({st, stb, exp_ill, exp_to, CW'(exp_cnt)}));
        if (stb[1]) exp_cnt = (exp_cnt + 1) % (1 << CW);
    endtask

    task automatic do_reset(input int n);
        exp_cnt = 0; exp_ill = 1'b0; exp_to = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = 1'b1; imem_ack = rb(); dmem_ack = rb(); alu_zero = rb(); inst = $urandom;
            #1;
            check("reset_outputs", observed(), 32'd0);
        end
    endtask

    task automatic run_error(input int n);
        for (int i = 0; i < n; i++) cyc("error_hold", rb(), rb(), rb(), $urandom, 9'h000, 3'd7);
    endtask

    task automatic check_cnt(input string tag, input int exp);
        @(posedge clk);
        #1;
        check(tag, 32'(retire_count), 32'(exp));
    endtask

    // One instruction: fwait/mwait no-ack cycles before the ack; abort_mem resets during MEM.
    task automatic run_instr(input logic [31:0] iw, input int fwait, input int mwait,
                             input logic z, input int abort_mem, output bit ended_err);
        cls_t       c;
        logic       simm;
        logic [8:0] stb;
        c = classify(iw[6:0]);
        simm = (c == C_I) || (c == C_LD) || (c == C_ST);
        ended_err = 1'b0;
        for (int k = 0; k < fwait && k < int'(TO); k++)
            cyc("fetch_wait", 1'b0, rb(), rb(), $urandom, 9'h100, 3'd0);
        if (fwait >= int'(TO)) begin
            exp_to = 1'b1; ended_err = 1'b1; return;
        end
        cyc("fetch_ack", 1'b1, rb(), rb(), iw, 9'h180, 3'd0);
        cyc("decode", rb(), rb(), rb(), $urandom, 9'h000, 3'd1);
        if (c == C_ILL) begin
            exp_ill = 1'b1; ended_err = 1'b1; return;
        end
        stb = '0; stb[4] = simm;
        if (c == C_BR) begin stb[1] = 1'b1; stb[0] = z; end
        cyc("exec", rb(), rb(), z, $urandom, stb, 3'd2);
        if (c == C_BR) return;
        if (c == C_LD || c == C_ST) begin
            stb = '0; stb[6] = 1'b1; stb[5] = (c == C_ST); stb[4] = 1'b1;
            for (int k = 0; k < mwait && k < int'(TO); k++) begin
                if (k == abort_mem) begin do_reset(2); return; end
                cyc("mem_wait", rb(), 1'b0, rb(), $urandom, stb, 3'd3);
            end
            if (mwait >= int'(TO)) begin
                exp_to = 1'b1; ended_err = 1'b1; return;
            end
            if (c == C_ST) begin
                stb[1] = 1'b1;
                cyc("mem_ack_store", rb(), 1'b1, rb(), $urandom, stb, 3'd3);
                return;
            end
            cyc("mem_ack_load", rb(), 1'b1, rb(), $urandom, stb, 3'd3);
        end
        stb = '0; stb[3] = (iw[11:7] != 5'd0); stb[2] = (c == C_LD); stb[1] = 1'b1;
        cyc("writeback", rb(), rb(), rb(), $urandom, stb, 3'd4);
    endtask

    initial begin
        bit          err;
        logic [6:0]  ops [5];
        logic [31:0] iw;
        int          fw, mw;
        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
        ops[3] = 7'b0100011; ops[4] = 7'b1100011;

        do_reset(3);
        run_instr(32'h002081B3, 0, 0, 1'b0, -1, err);
        check_cnt("add_retire", 1);

        do_reset(1);
        run_instr(32'h008A2283, 0, 3, 1'b0, -1, err);
        check_cnt("lw_retire", 1);

        run_instr(32'h00208463, 0, 0, 1'b1, -1, err);
        run_instr(32'h00208463, 0, 0, 1'b0, -1, err);
        check_cnt("beq_retire", 3);

        run_instr(32'h00000013, 0, 0, 1'b0, -1, err);
        run_instr(32'h0000007F, 0, 0, 1'b0, -1, err);
        run_error(20);
        do_reset(1);

        run_instr(32'h002081B3, int'(TO), 0, 1'b0, -1, err);
        run_error(3);
        do_reset(1);
        run_instr(32'h002081B3, int'(TO) - 1, 0, 1'b0, -1, err);
        run_instr(32'h00112023, 1, int'(TO), 1'b0, -1, err);
        run_error(3);

        do_reset(1);
        for (int i = 0; i < 17; i++) begin
            iw = $urandom; iw[6:0] = 7'b0010011;
            run_instr(iw, 0, 0, 1'b0, -1, err);
        end
        check_cnt("wrap_retire", 1);

        run_instr(32'h008A2283, 0, 3, 1'b0, 2, err);
        run_instr(32'h002081B3, 0, 0, 1'b0, -1, err);
        check_cnt("abort_retire", 1);

        for (int i = 0; i < 150; i++) begin
            iw = $urandom;
            if ($urandom_range(0, 19) != 0) iw[6:0] = ops[$urandom_range(0, 4)];
            fw = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, TO));
            mw = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, TO));
            run_instr(iw, fw, mw, rb(), -1, err);
            if (err) begin
                run_error(2);
                do_reset(1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rv64_multicycle_ctrl.md
Name: rv64_multicycle_ctrl

Overview:
- Multi-cycle control FSM that sequences the 64-bit RISC-V single-issue datapath (decoder, register file, ALU, instruction and data memory ports).
- Issues the fetch and memory request handshakes, and generates PC, register-file write, ALU-source and write-back strobes for each instruction class.
- Detects illegal opcodes and memory timeouts; counts retired instructions.

Parameters:
- MEM_TIMEOUT, 16, max cycles a request may wait for ack before ERROR (legal 2..255).
- CNT_W, 32, width of retire counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  fetch complete; inst valid this cycle.
- inst  in  32  instruction word from instruction memory.
- ir_load  out  1  one-cycle pulse: datapath latches inst into IR.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req=1.
- dmem_ack  in  1  data access complete.
- alu_zero  in  1  ALU equality-compare result.
- alu_src_imm  out  1  ALU operand B = immediate.
- rf_wen  out  1  register-file write enable.
- wb_sel  out  1  0 = ALU result, 1 = load data.
- pc_write  out  1  PC update strobe.
- pc_sel  out  1  0 = PC+4, 1 = branch target.
- illegal  out  1  sticky illegal-opcode flag.
- timeout  out  1  sticky memory-timeout flag.
- state  out  3  current state, for debug.
- retire_count  out  CNT_W  retired instruction count.

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERROR=7. Codes 5 and 6 are unused and go to ERROR.
- Reset:
  - Sync, priority over everything: state=FETCH; illegal=0; timeout=0; retire_count=0; wait counter=0.
  - All outputs are forced 0 while reset=1. Acks are ignored while reset=1.
  - Reset mid-transaction abandons the access; no PC or register write occurs.
- FETCH:
  - imem_req=1 for every cycle in this state.
  - On imem_ack: ir_load=1 that same cycle; latch inst[6:0] as opcode and inst[11:7] as rd; go to DECODE.
- DECODE (1 cycle):
  - Opcode 0110011 (R), 0010011 (I), 0000011 (LOAD), 0100011 (STORE), 1100011 (BRANCH) go to EXEC.
  - Any other opcode: go to ERROR and set illegal=1.
- EXEC (1 cycle):
  - alu_src_imm=1 for I, LOAD and STORE; 0 for R and BRANCH.
  - R and I go to WB. LOAD and STORE go to MEM.
  - BRANCH: pc_write=1, pc_sel=alu_zero, retire, go to FETCH.
- MEM:
  - dmem_req=1 for every cycle in this state; dmem_we=1 for STORE; alu_src_imm stays 1.
  - On dmem_ack: LOAD goes to WB. STORE asserts pc_write=1 with pc_sel=0, retires, and goes to FETCH.
- WB (1 cycle):
  - rf_wen=1 unless rd==0, in which case rf_wen=0 (x0 is never written).
  - wb_sel=1 for LOAD, 0 otherwise.
  - pc_write=1, pc_sel=0, retire, go to FETCH.
- ERROR:
  - Terminal until reset; all strobes 0.
  - Flags stay set.
- Wait counter:
  - Clears on entry to FETCH and to MEM; increments each cycle req=1 and ack=0.
  - When it reaches MEM_TIMEOUT with ack still 0: go to ERROR and set timeout=1.
  - Ack arriving in the same cycle the count reaches MEM_TIMEOUT wins: normal transition, no timeout.
- Latency: R/I = 4 cycles with 0-wait fetch; BRANCH = 3; STORE = 4; LOAD = 5, plus memory wait cycles.
- retire_count:
  - Increments by 1 in the cycle pc_write=1.
  - Wraps modulo 2^CNT_W; no saturation.
- Ack protocol:
  - Acks outside the matching request state are ignored.
  - imem_ack and dmem_ack are never both acted upon in one cycle.
- All outputs are decoded from registered state plus same-cycle ack, alu_zero and latched opcode/rd. No latches; no X or Z outputs.

Test Plan:
- Reset, then 0-wait fetch of ADD x3,x1,x2 (0x002081B3) -> ir_load in cycle 1; state 0,1,2,4; rf_wen=1, wb_sel=0 in WB; pc_write in cycle 4; retire_count=1.
- LW x5,8(x20) (0x008A2283) with dmem_ack delayed 3 cycles -> dmem_req=1, dmem_we=0 for 4 cycles; then WB with wb_sel=1, rf_wen=1; retire_count=1.
- BEQ (opcode 1100011) with alu_zero=1, then again with alu_zero=0 -> pc_sel=1 then pc_sel=0; each takes 3 cycles; no rf_wen.
- ADDI x0,x0,0 (0x00000013) -> WB reached with rf_wen=0, pc_write=1. Then opcode 1111111 -> ERROR, illegal=1, all strobes 0 for 20 cycles; reset clears it.
- MEM_TIMEOUT=4, no imem_ack -> ERROR after 4 req cycles, timeout=1. Repeat with ack on the 4th cycle -> no timeout, DECODE.
- CNT_W=4, 17 back-to-back ADDIs -> retire_count wraps to 1. Reset asserted in a MEM wait -> state=0, no pc_write or rf_wen, count=0.
